alu_arbiter: RTL and testbench

- Shares one combinational 64-bit ALU between NREQ requesters, e.g. execute stage, branch compare and address generation.
- Each cycle it picks one valid request by round-robin and drives its operands and op onto the ALU.
- It captures the ALU outputs in a one-entry response register. The response carries a requester id and uses a valid/ready handshake.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_arbiter_if.sv | 42 ++++
 rtl/rr_arbiter.sv | 34 +++
 rtl/alu_arbiter.sv | 92 +++++++++
 tb/tb_alu_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, datapath width and op legality check
package alu_pkg;

  localparam int XLEN = 64;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [3:0]      alu_op_t;

  localparam alu_op_t ALU_AND  = 4'b0000;
  localparam alu_op_t ALU_OR   = 4'b0001;
  localparam alu_op_t ALU_ADD  = 4'b0010;
  localparam alu_op_t ALU_SUB  = 4'b0110;
  localparam alu_op_t ALU_SLT  = 4'b0111;
  localparam alu_op_t ALU_XOR  = 4'b1000;
  localparam alu_op_t ALU_SLL  = 4'b1001;
  localparam alu_op_t ALU_SRL  = 4'b1010;
  localparam alu_op_t ALU_SRA  = 4'b1011;
  localparam alu_op_t ALU_SLTU = 4'b1100;

  function automatic logic alu_op_legal(input alu_op_t op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT,
      ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLTU: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request, shared-ALU and response signals of the ALU arbiter
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*XLEN-1:0] req_a;
  logic [NREQ*XLEN-1:0] req_b;
  logic [NREQ*4-1:0]    req_op;

  word_t                alu_a;
  word_t                alu_b;
  alu_op_t              alu_control;
  word_t                alu_result;
  logic                 alu_zero;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  word_t                rsp_result;
  logic                 rsp_zero;
  logic                 rsp_illegal;

  // Arbiter side
  modport master (
    input  req_valid, req_a, req_b, req_op, alu_result, alu_zero, rsp_ready,
    output req_ready, alu_a, alu_b, alu_control,
           rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal
  );

  // Requesters, ALU and response consumer side
  modport slave (
    output req_valid, req_a, req_b, req_op, alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_control,
           rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick starting at ptr; one-hot grant gated by enable
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            found
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IDW-1:0]    off;
  logic [IDW:0]      sum;

  always_comb begin
    // Rotate so that bit 0 is the requester at ptr, then take the lowest set bit.
    dbl = {req, req} >> ptr;
    rot = dbl[NREQ-1:0];
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = IDW'(k);
    end
    found = |rot;
    sum   = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
    idx   = sum[IDW-1:0];
    grant = (found && enable) ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one combinational ALU between NREQ requesters
// with round-robin grant and a one-entry valid/ready response register.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.master bus
);

  logic [IDW-1:0]  rr_ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_found;
  logic            can_issue;
  logic            accept;

  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  word_t           rsp_result_q;
  logic            rsp_zero_q;
  logic            rsp_illegal_q;

  word_t           a_arr  [NREQ];
  word_t           b_arr  [NREQ];
  alu_op_t         op_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i]  = bus.req_a[XLEN*i +: XLEN];
    assign b_arr[i]  = bus.req_b[XLEN*i +: XLEN];
    assign op_arr[i] = bus.req_op[4*i +: 4];
  end

  assign can_issue = !rsp_valid_q || bus.rsp_ready;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req    (bus.req_valid),
    .ptr    (rr_ptr),
    .enable (can_issue && !rst),
    .grant  (grant),
    .idx    (gnt_idx),
    .found  (gnt_found)
  );

  assign bus.req_ready = grant;
  assign accept        = |grant;

  // The ALU sees the grantee even under backpressure; only the accept is held off.
  always_comb begin
    bus.alu_a       = '0;
    bus.alu_b       = '0;
    bus.alu_control = ALU_AND;
    if (gnt_found) begin
      bus.alu_a       = a_arr[gnt_idx];
      bus.alu_b       = b_arr[gnt_idx];
      bus.alu_control = op_arr[gnt_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
      rr_ptr        <= '0;
    end else if (accept) begin
      rsp_valid_q   <= 1'b1;
      rsp_id_q      <= gnt_idx;
      rsp_result_q  <= bus.alu_result;
      rsp_zero_q    <= bus.alu_zero;
      rsp_illegal_q <= !alu_op_legal(op_arr[gnt_idx]);
      rr_ptr        <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end else if (bus.rsp_ready) begin
      rsp_valid_q   <= 1'b0;
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_zero    = rsp_zero_q;
  assign bus.rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - bench for alu_arbiter with a behavioural ALU and response model
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  function automatic logic [63:0] alu_f(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return {63'd0, $signed(a) < $signed(b)};
      4'b1000: return a ^ b;
      4'b1001: return a << b[5:0];
      4'b1010: return a >> b[5:0];
      4'b1011: return $unsigned($signed(a) >>> b[5:0]);
      4'b1100: return {63'd0, a < b};
      default: return 64'd0;
    endcase
  endfunction

  assign bus.alu_result = alu_f(bus.alu_a, bus.alu_b, bus.alu_control);
  assign bus.alu_zero   = (bus.alu_result == 64'd0);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: what the response register and round-robin order must be.
  bit          m_valid = 1'b0;
  int          m_id    = 0;
  logic [63:0] m_res   = '0;
  bit          m_zero  = 1'b0;
  bit          m_ill   = 1'b0;
  int          m_next  = 0;

  function automatic logic [63:0] a_of(input int i);
    return bus.req_a[64*i +: 64];
  endfunction
  function automatic logic [63:0] b_of(input int i);
    return bus.req_b[64*i +: 64];
  endfunction
  function automatic logic [3:0] op_of(input int i);
    return bus.req_op[4*i +: 4];
  endfunction

  function automatic int pick();
    for (int k = 0; k < NREQ; k++) begin
      if (bus.req_valid[(m_next + k) % NREQ]) return (m_next + k) % NREQ;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    logic [3:0] op;
    if (rst) begin
      m_valid = 1'b0; m_id = 0; m_res = '0; m_zero = 1'b0; m_ill = 1'b0; m_next = 0;
    end else begin
      g = pick();
      if (g >= 0 && (!m_valid || bus.rsp_ready)) begin
        op      = op_of(g);
        m_ill   = !(op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                               4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100});
        m_res   = m_ill ? 64'd0 : alu_f(a_of(g), b_of(g), op);
        m_zero  = (m_res == 64'd0);
        m_id    = g;
        m_valid = 1'b1;
        m_next  = (g + 1) % NREQ;
      end else if (m_valid && bus.rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [NREQ-1:0] er;
    g  = pick();
    er = '0;
    if (!rst && g >= 0 && (!m_valid || bus.rsp_ready)) er[g] = 1'b1;
    chk("m_req_ready", 64'(bus.req_ready), 64'(er));
    chk("m_alu_a", bus.alu_a, (g >= 0) ? a_of(g) : 64'd0);
    chk("m_alu_b", bus.alu_b, (g >= 0) ? b_of(g) : 64'd0);
    chk("m_alu_control", 64'(bus.alu_control), (g >= 0) ? 64'(op_of(g)) : 64'd0);
    chk("m_rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
    chk("m_rsp_id", 64'(bus.rsp_id), 64'(m_id));
    chk("m_rsp_result", bus.rsp_result, m_res);
    chk("m_rsp_zero", 64'(bus.rsp_zero), 64'(m_zero));
    chk("m_rsp_illegal", 64'(bus.rsp_illegal), 64'(m_ill));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string nm, input int idx, input logic [3:0] op,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp_r, input logic exp_z, input logic exp_i);
    int n;
    cyc();
    bus.req_a[64*idx +: 64] = a;
    bus.req_b[64*idx +: 64] = b;
    bus.req_op[4*idx +: 4]  = op;
    bus.req_valid[idx]      = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready[idx] && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_ready"}, 64'(bus.req_ready[idx]), 64'd1);
    cyc();
    bus.req_valid[idx] = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, 64'(bus.rsp_valid), 64'd1);
    chk({nm, "_id"}, 64'(bus.rsp_id), 64'(idx));
    chk({nm, "_result"}, bus.rsp_result, exp_r);
    chk({nm, "_zero"}, 64'(bus.rsp_zero), 64'(exp_z));
    chk({nm, "_illegal"}, 64'(bus.rsp_illegal), 64'(exp_i));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b1;

    // Reset: requests present but nothing may be accepted.
    cyc();
    bus.req_valid = 2'b11;
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    cyc();
    bus.req_valid = '0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_rsp_result", bus.rsp_result, 64'd0);
    chk("rst_rsp_zero", 64'(bus.rsp_zero), 64'd0);
    chk("rst_rsp_illegal", 64'(bus.rsp_illegal), 64'd0);

    issue("add", 0, 4'b0010, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0);
    issue("and", 1, 4'b0000, 64'hF0F0, 64'h0FF0, 64'h00F0, 1'b0, 1'b0);

    // Contention: both valid, grants must alternate starting at 0.
    cyc();
    bus.req_a[63:0]   = 64'd9;  bus.req_b[63:0]   = 64'd9;  bus.req_op[3:0] = 4'b0110;
    bus.req_a[127:64] = 64'hF0; bus.req_b[127:64] = 64'h0F; bus.req_op[7:4] = 4'b1000;
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      chk("cont_id", 64'(bus.rsp_id), 64'(k % 2));
      chk("cont_result", bus.rsp_result, (k % 2) ? 64'hFF : 64'd0);
      chk("cont_zero", 64'(bus.rsp_zero), (k % 2) ? 64'd0 : 64'd1);
    end

    // Backpressure: one accept, then three stalled cycles.
    cyc();
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
      chk("bp_rsp_id", 64'(bus.rsp_id), 64'd0);
      chk("bp_rsp_result", bus.rsp_result, 64'd0);
      chk("bp_rsp_zero", 64'(bus.rsp_zero), 64'd1);
      cyc();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(bus.req_ready), 64'b10);
    cyc();
    @(negedge clk);
    chk("bp_release_id", 64'(bus.rsp_id), 64'd1);
    chk("bp_release_result", bus.rsp_result, 64'hFF);
    cyc();
    bus.req_valid = '0;
    cyc();

    issue("slt", 0, 4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 1'b0);
    issue("sltu", 0, 4'b1100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0);
    issue("sra", 0, 4'b1011, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 1'b0, 1'b0);
    issue("srl", 1, 4'b1010, 64'h8000_0000_0000_0000, 64'h3F, 64'd1, 1'b0, 1'b0);
    issue("sll", 1, 4'b1001, 64'd1, 64'h44, 64'd16, 1'b0, 1'b0);
    issue("sub_wrap", 0, 4'b0110, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    issue("or", 1, 4'b0001, 64'hA0, 64'h05, 64'hA5, 1'b0, 1'b0);
    issue("illegal", 0, 4'b0011, 64'd3, 64'd4, 64'd0, 1'b1, 1'b1);
    issue("illegal_hi", 1, 4'b1111, 64'd3, 64'd4, 64'd0, 1'b1, 1'b1);

    // Reset while a response is held and req1 is waiting.
    cyc();
    bus.rsp_ready = 1'b0;
    bus.req_a[63:0] = 64'd1; bus.req_b[63:0] = 64'd2; bus.req_op[3:0] = 4'b0010;
    bus.req_valid = 2'b01;
    @(negedge clk);
    chk("rm_first_ready", 64'(bus.req_ready), 64'b01);
    cyc();
    bus.req_valid = 2'b10;
    bus.req_a[127:64] = 64'd8; bus.req_b[127:64] = 64'd1; bus.req_op[7:4] = 4'b0001;
    @(negedge clk);
    chk("rm_held_valid", 64'(bus.rsp_valid), 64'd1);
    chk("rm_bp_ready", 64'(bus.req_ready), 64'd0);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("rm_rst_ready", 64'(bus.req_ready), 64'd0);
    cyc();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b11;
    @(negedge clk);
    chk("rm_dropped", 64'(bus.rsp_valid), 64'd0);
    chk("rm_ptr_zero", 64'(bus.req_ready), 64'b01);
    cyc();
    bus.req_valid = '0;
    @(negedge clk);
    chk("rm_after_id", 64'(bus.rsp_id), 64'd0);
    chk("rm_after_result", bus.rsp_result, 64'd3);
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
